// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle controller and the ALU: FSM states,
// ALU operation codes, the 2-bit alu_op class and the supported opcodes.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_JAL,
    S_BEQ
  } state_t;

  typedef enum logic [1:0] {
    ALU_OP_ADD   = 2'b00,
    ALU_OP_SUB   = 2'b01,
    ALU_OP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  // Immediate format select; I-type and lw share format 00.
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_SW:   imm_src_of = 2'b01;
      OP_BEQ:  imm_src_of = 2'b10;
      OP_JAL:  imm_src_of = 2'b11;
      default: imm_src_of = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Instruction-field inputs and datapath control outputs of the multicycle controller.
// The slave modport is the controller side; master is the datapath side.
interface multicycle_control_if;
  import multicycle_control_pkg::*;

  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;

  logic [2:0] alu_control;
  logic       pc_write;
  logic       ir_write;
  logic       mem_write;
  logic       reg_write;
  logic       adr_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic [1:0] imm_src;
  state_t     state;

  modport slave (
    input  op, funct3, funct7b5, zero,
    output alu_control, pc_write, ir_write, mem_write, reg_write, adr_src,
           alu_src_a, alu_src_b, result_src, imm_src, state
  );

  modport master (
    output op, funct3, funct7b5, zero,
    input  alu_control, pc_write, ir_write, mem_write, reg_write, adr_src,
           alu_src_a, alu_src_b, result_src, imm_src, state
  );
endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// Combinational ALU decoder: maps alu_op class plus funct fields to alu_control.
// Zero latency, no handshake.
module alu_decoder
  import multicycle_control_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALU_OP_SUB: alu_control = ALU_SUB;
      ALU_OP_FUNCT: begin
        case (funct3)
          // addi never subtracts: op5 separates R-type sub from I-type add
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore FSM controller for a multicycle RISC-V datapath; one state per clk, no stall.
// Latency lw 5, sw/R/I/jal 4, beq 3, unsupported 2 cycles; write enables held low during reset.
module multicycle_control
  import multicycle_control_pkg::*;
(
  input logic                 clk,
  input logic                 rst_n,
  multicycle_control_if.slave bus
);

  state_t     state_q, state_d;
  alu_op_t    alu_op;
  logic       pc_write_c, ir_write_c, mem_write_c, reg_write_c, adr_src_c;
  logic [1:0] alu_src_a_c, alu_src_b_c, result_src_c;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = S_FETCH;
    alu_op       = ALU_OP_ADD;
    pc_write_c   = 1'b0;
    ir_write_c   = 1'b0;
    mem_write_c  = 1'b0;
    reg_write_c  = 1'b0;
    adr_src_c    = 1'b0;
    alu_src_a_c  = 2'b00;
    alu_src_b_c  = 2'b00;
    result_src_c = 2'b00;
    case (state_q)
      S_FETCH: begin
        ir_write_c   = 1'b1;
        pc_write_c   = 1'b1;
        alu_src_b_c  = 2'b10;
        result_src_c = 2'b10;
        state_d      = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a_c = 2'b01;
        alu_src_b_c = 2'b01;
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECR;
          OP_ITYPE:     state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alu_src_a_c = 2'b10;
        alu_src_b_c = 2'b01;
        state_d     = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src_c = 1'b1;
        state_d   = S_MEMWB;
      end
      S_MEMWB: begin
        result_src_c = 2'b01;
        reg_write_c  = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src_c   = 1'b1;
        mem_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a_c = 2'b10;
        alu_op      = ALU_OP_FUNCT;
        state_d     = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a_c = 2'b10;
        alu_src_b_c = 2'b01;
        alu_op      = ALU_OP_FUNCT;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_JAL: begin
        alu_src_a_c = 2'b01;
        alu_src_b_c = 2'b10;
        pc_write_c  = 1'b1;
        state_d     = S_ALUWB;
      end
      S_BEQ: begin
        alu_src_a_c = 2'b10;
        alu_op      = ALU_OP_SUB;
        // The only output that looks at a live input rather than the state
        pc_write_c  = bus.zero;
        state_d     = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (bus.funct3),
    .op5         (bus.op[5]),
    .funct7b5    (bus.funct7b5),
    .alu_control (bus.alu_control)
  );

  assign bus.pc_write   = rst_n & pc_write_c;
  assign bus.ir_write   = rst_n & ir_write_c;
  assign bus.mem_write  = rst_n & mem_write_c;
  assign bus.reg_write  = rst_n & reg_write_c;
  assign bus.adr_src    = adr_src_c;
  assign bus.alu_src_a  = alu_src_a_c;
  assign bus.alu_src_b  = alu_src_b_c;
  assign bus.result_src = result_src_c;
  assign bus.imm_src    = imm_src_of(bus.op);
  assign bus.state      = state_q;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have no parameters; all encodings come from the shared package.
REQ-002 SHALL have port: clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port: rst_n  in  1  reset; one clock; reset is synchronous and active-low.
REQ-004 SHALL have port: op  in  7  instr[6:0], valid when ir_write is low.
REQ-005 SHALL have port: funct3  in  3  instr[14:12].
REQ-006 SHALL have port: funct7b5  in  1  instr[30].
REQ-007 SHALL have port: zero  in  1  ALU zero flag, combinational from the ALU.
REQ-008 SHALL have port: alu_control  out  3  ALU operation: ADD 000, SUB 001, AND 010, OR 011, SLT 101.
REQ-009 SHALL have ports pc_write, ir_write, mem_write, reg_write, adr_src  out  1 each  write enables and address mux select.
REQ-010 SHALL have ports alu_src_a, alu_src_b, result_src, imm_src  out  2 each  datapath mux and immediate selects.

Function
REQ-011 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, JAL, BEQ.
REQ-012 SHALL advance one state per clk edge; it has no stall input.
REQ-013 FETCH: adr_src=0, ir_write=1, alu_src_a=00, alu_src_b=10, ADD, result_src=10, pc_write=1; next state DECODE.
REQ-014 DECODE: alu_src_a=01, alu_src_b=01, ADD (branch target).
REQ-014a DECODE next state by op: 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1101111 -> JAL; 1100011 -> BEQ; any other op -> FETCH, with no writes (NOP).
REQ-015 MEMADR: alu_src_a=10, alu_src_b=01, ADD; next state MEMREAD if op=0000011, else MEMWRITE.
REQ-016 MEMREAD: result_src=00, adr_src=1; next state MEMWB.
REQ-016a MEMWB: result_src=01, reg_write=1; next state FETCH.
REQ-017 MEMWRITE: result_src=00, adr_src=1, mem_write=1; next state FETCH.
REQ-018 EXECR: alu_src_a=10, alu_src_b=00, funct decode. EXECI: alu_src_a=10, alu_src_b=01, funct decode. Both go next to ALUWB.
REQ-019 ALUWB: result_src=00, reg_write=1; next state FETCH.
REQ-020 JAL: alu_src_a=01, alu_src_b=10, ADD, result_src=00, pc_write=1; next state ALUWB.
REQ-021 BEQ: alu_src_a=10, alu_src_b=00, SUB, result_src=00; pc_write=zero, the only Mealy output; next state FETCH.
REQ-022 Funct decode: funct3 000 -> SUB if op[5] and funct7b5 both 1, else ADD; 010 -> SLT; 110 -> OR; 111 -> AND; any other -> ADD.
REQ-023 imm_src SHALL be decoded combinationally from op in every state: I/lw 00, sw 01, beq 10, jal 11, other 00.
REQ-024 Any enable or select not listed for a state SHALL be 0/00.
REQ-025 Instruction latency SHALL be: lw 5 cycles, sw 4, R/I 4, jal 4, beq 3, unsupported 2.

Reset
REQ-026 rst_n low at a clk edge SHALL set state=FETCH, including mid-instruction.
REQ-027 While rst_n is low, pc_write, ir_write, mem_write and reg_write SHALL be forced 0, so no architectural write occurs.
REQ-028 The first FETCH writes SHALL occur in the first cycle after rst_n is sampled high.

Structure
REQ-029 The state enum, the alu_control encodings, the 2-bit alu_op (ADD/SUB/FUNCT) and the opcode constants SHALL live in the shared package, which the ALU also imports.
REQ-030 Funct decode SHALL be a combinational sub-module alu_decoder (inputs alu_op, funct3, op5, funct7b5; output alu_control).
REQ-031 The state register SHALL be the only storage element.

Verification
REQ-032 Reset: hold rst_n=0 for 3 cycles from a random state -> all write enables 0; the first cycle after release is FETCH with ir_write=1 and pc_write=1.
REQ-033 lw (op=0000011): state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB -> reg_write=1 only in MEMWB, result_src=01 there.
REQ-034 sub (op=0110011, funct3=000, funct7b5=1) -> alu_control=001 in EXECR; with funct7b5=0 -> 000; addi with funct7b5=1 -> 000.
REQ-035 beq: zero=1 -> pc_write=1 in BEQ; zero=0 -> pc_write=0; both then return to FETCH.
REQ-036 and/or (funct3=111/110) -> alu_control 010/011; unsupported op=0000000 -> DECODE then FETCH, with no mem_write or reg_write.
REQ-037 rst_n dropped in MEMWRITE -> mem_write is 0 in that cycle, and the state is FETCH after release.
